// File: rtl/tanh_lut_arbiter_if.sv
// Request/result bundle between the accumulator array, the tanh arbiter and the next layer.
// Latency: none (wires only).
// Backpressure: req_ready grants requesters; res_ready throttles the result stream.
interface tanh_lut_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ACC_W   = 24,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*ACC_W-1:0] req_acc;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     res_valid;
    logic                     res_ready;
    logic [15:0]              res_data;
    logic [ID_W-1:0]          res_id;

    // Requester/consumer side
    modport master (
        output req_valid, req_acc, res_ready,
        input  req_ready, res_valid, res_data, res_id
    );

    // Arbiter side
    modport slave (
        input  req_valid, req_acc, res_ready,
        output req_ready, res_valid, res_data, res_id
    );
endinterface

// File: rtl/tanh_lut_arbiter.sv
// Generic show-ahead FIFO used for the tagged tanh results.
// Latency: write visible at the head one cycle after push; head read is combinational.
// Backpressure: pops only when out_rdy; a push into a full FIFO is accepted only with a same-cycle pop.
module tanh_lut_arbiter_fifo #(
    parameter int W     = 18,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_vld,
    input  logic [W-1:0]               in_dat,
    output logic                       out_vld,
    input  logic                       out_rdy,
    output logic [W-1:0]               out_dat,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop;

    // Next-state for storage, pointers and occupancy; push and pop may coincide at any fill level
    always_comb begin
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        do_pop  = out_rdy && (cnt_q != '0);
        do_push = in_vld && ((cnt_q != FULL) || do_pop);
        if (do_push) begin
            mem_d[wr_q] = in_dat;
            wr_d        = wr_q + AW'(1);
        end
        if (do_pop) begin
            rd_d = rd_q + AW'(1);
        end
        cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    assign out_vld = (cnt_q != '0);
    assign out_dat = out_vld ? mem_q[rd_q] : '0;
    assign count   = cnt_q;
endmodule

// Round-robin share of one tanh LUT among NUM_REQ accumulators, results tagged by requester ID.
// Latency: grant in T -> lut_addr in T+1 -> result at FIFO head in T+2 at the earliest.
// Backpressure: grants only while (reads in flight + FIFO entries) < RES_DEPTH; results held under res_ready=0.
module tanh_lut_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int ACC_W     = 24,
    parameter int RES_DEPTH = 4,
    parameter int ID_W      = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    tanh_lut_arbiter_if.slave    bus,
    output logic [7:0]           lut_addr,
    input  logic [15:0]          lut_data,
    output logic                 busy
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(RES_DEPTH) + 1;
    localparam int CW1   = CNT_W + 1;
    localparam logic [CW1-1:0] CREDIT_LIM = CW1'(RES_DEPTH);

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [15:0]     dat;
    } res_t;

    // Arbitration state and LUT read stage
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [7:0]       lut_addr_q, lut_addr_d;
    logic [ID_W-1:0]  tag_q, tag_d;
    logic             rd_vld_q, rd_vld_d;
    logic             en_q, en_d;

    logic [PTR_W-1:0]   gnt_idx, cand;
    logic               gnt_found;
    logic               credit_ok;
    logic               xfer;
    logic [NUM_REQ-1:0] req_ready;
    logic [CW1-1:0]     used;

    logic [ACC_W-1:0]   acc_sel;
    logic [ACC_W-16:0]  acc_upper;
    logic [15:0]        sat_val;
    logic [7:0]         lut_idx;

    res_t               push_dat, head_dat;
    logic               fifo_vld;
    logic [CNT_W-1:0]   fifo_cnt;

    // Round-robin search starting one past the last winner
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = PTR_W'((int'(ptr_q) + k) % NUM_REQ);
            if (!gnt_found && bus.req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    // Credit: every grant owns a FIFO slot until its result is popped; en_q keeps grants off during reset
    always_comb begin
        used      = CW1'(rd_vld_q) + CW1'(fifo_cnt);
        credit_ok = en_q && (used < CREDIT_LIM);
        req_ready = (gnt_found && credit_ok) ? (NUM_REQ'(1) << gnt_idx) : '0;
        xfer      = |(bus.req_valid & req_ready);
    end

    // Clamp the winning accumulator to Q4.12 and map it to the LUT index (s>>>8)+128
    always_comb begin
        acc_sel   = bus.req_acc[gnt_idx*ACC_W +: ACC_W];
        acc_upper = acc_sel[ACC_W-1:15];
        if ((&acc_upper) || (~|acc_upper)) begin
            sat_val = acc_sel[15:0];
        end else if (acc_sel[ACC_W-1]) begin
            sat_val = 16'h8000;
        end else begin
            sat_val = 16'h7FFF;
        end
        lut_idx = {~sat_val[15], sat_val[14:8]};
    end

    // Next-state for pointer, LUT address, tag and the read-in-flight flag
    always_comb begin
        ptr_d      = ptr_q;
        lut_addr_d = lut_addr_q;
        tag_d      = tag_q;
        rd_vld_d   = xfer;
        en_d       = 1'b1;
        if (xfer) begin
            ptr_d      = gnt_idx;
            lut_addr_d = lut_idx;
            tag_d      = ID_W'(gnt_idx);
        end
    end

    // Pipeline registers; lut_addr holds its last value when nothing is granted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q      <= PTR_W'(NUM_REQ - 1);
            lut_addr_q <= 8'h80;
            tag_q      <= '0;
            rd_vld_q   <= 1'b0;
            en_q       <= 1'b0;
        end else begin
            ptr_q      <= ptr_d;
            lut_addr_q <= lut_addr_d;
            tag_q      <= tag_d;
            rd_vld_q   <= rd_vld_d;
            en_q       <= en_d;
        end
    end

    // LUT data returned the cycle after the address register loads is captured with its tag
    always_comb begin
        push_dat.id  = tag_q;
        push_dat.dat = lut_data;
    end

    tanh_lut_arbiter_fifo #(
        .W     ($bits(res_t)),
        .DEPTH (RES_DEPTH)
    ) u_res_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_vld  (rd_vld_q),
        .in_dat  (push_dat),
        .out_vld (fifo_vld),
        .out_rdy (bus.res_ready),
        .out_dat (head_dat),
        .count   (fifo_cnt)
    );

    assign bus.req_ready = req_ready;
    assign bus.res_valid = fifo_vld;
    assign bus.res_data  = head_dat.dat;
    assign bus.res_id    = head_dat.id;
    assign lut_addr      = lut_addr_q;
    assign busy          = rd_vld_q | (fifo_cnt != '0);
endmodule

// File: tb/tb_tanh_lut_arbiter.sv
// Bench for tanh_lut_arbiter: directed cases plus random traffic against a queue-based reference.
// Latency modelled: result available two cycles after its grant, in grant order.
// Backpressure modelled: at most RES_DEPTH results outstanding from grant to pop.
module tb_tanh_lut_arbiter;
    localparam int NUM_REQ   = 4;
    localparam int ACC_W     = 24;
    localparam int RES_DEPTH = 4;
    localparam int ID_W      = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  lut_addr;
    logic [15:0] lut_data;
    logic        busy;
    logic [15:0] lut_mem [256];

    tanh_lut_arbiter_if #(.NUM_REQ(NUM_REQ), .ACC_W(ACC_W), .ID_W(ID_W)) bus ();

    tanh_lut_arbiter #(
        .NUM_REQ(NUM_REQ), .ACC_W(ACC_W), .RES_DEPTH(RES_DEPTH), .ID_W(ID_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .lut_addr (lut_addr),
        .lut_data (lut_data),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // LUT contents are random; its read register is the DUT's lut_addr
    assign lut_data = lut_mem[lut_addr];

    typedef struct {
        int id;
        int idx;
        int avail;
    } ent_t;

    ent_t q[$];
    int   ptr, last_addr, cyc, mdl_gnt;
    bit   armed;
    int   n_tests = 0;
    int   n_fail  = 0;
    bit               v     [NUM_REQ];
    logic [ACC_W-1:0] acc_a [NUM_REQ];
    logic [NUM_REQ-1:0] obs_rdy, obs_xfer;

    logic [23:0] sat_acc [5] = '{24'h100000, 24'h800000, 24'hFF8000, 24'h000000, 24'hFFFF00};
    logic [7:0]  sat_exp [5] = '{8'hFF, 8'h00, 8'h00, 8'h80, 8'h7F};

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Clamp to signed 16 bits, then divide by 256 and recentre on 128
    function automatic int sat_idx(input logic [23:0] a);
        int x;
        x = $signed(a);
        if (x > 32767) x = 32767;
        if (x < -32768) x = -32768;
        return (x >>> 8) + 128;
    endfunction

    function automatic logic [23:0] rand_acc();
        logic [23:0] r;
        r = '0;
        case ($urandom_range(3))
            0: r = 24'($urandom);
            1: r = 24'($urandom_range(65535)) - 24'd32768;
            2: case ($urandom_range(5))
                   0: r = 24'h007FFF;
                   1: r = 24'hFF8000;
                   2: r = 24'h800000;
                   3: r = 24'h7FFFFF;
                   4: r = 24'h008000;
                   default: r = 24'hFF7FFF;
               endcase
            default: r = 24'h000000;
        endcase
        return r;
    endfunction

    task automatic apply();
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_valid[i] = v[i];
            bus.req_acc[i*ACC_W +: ACC_W] = acc_a[i];
        end
    endtask

    // Requesters only change after being granted or while idle
    task automatic drive_next(input logic [NUM_REQ-1:0] mask, input int pct);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!v[i] || mdl_gnt == i) begin
                v[i]     = mask[i] && (int'($urandom_range(99)) < pct);
                acc_a[i] = rand_acc();
            end
        end
        mdl_gnt = -1;
        apply();
    endtask

    task automatic model_reset();
        q.delete();
        ptr       = NUM_REQ - 1;
        last_addr = 8'h80;
        armed     = 1'b0;
        mdl_gnt   = -1;
    endtask

    // One clock: check outputs mid-cycle against the reference, then advance the reference
    task automatic cycle();
        int   c;
        bit   found;
        bit   exp_rv;
        bit   pop;
        int   idx;
        ent_t e;
        logic [NUM_REQ-1:0] exp_rdy;
        found   = 1'b0;
        mdl_gnt = -1;
        @(negedge clk);
        if (armed && q.size() < RES_DEPTH) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                c = (ptr + k) % NUM_REQ;
                if (!found && v[c]) begin
                    found   = 1'b1;
                    mdl_gnt = c;
                end
            end
        end
        exp_rdy  = found ? (NUM_REQ'(1) << mdl_gnt) : '0;
        obs_rdy  = bus.req_ready;
        obs_xfer = bus.req_ready & bus.req_valid;
        check_val("req_ready", obs_rdy, exp_rdy);
        check_val("lut_addr", lut_addr, last_addr);
        exp_rv = (q.size() != 0) && (q[0].avail <= cyc);
        check_val("res_valid", bus.res_valid, exp_rv);
        if (exp_rv) begin
            check_val("res_data", bus.res_data, lut_mem[q[0].idx]);
            check_val("res_id", bus.res_id, q[0].id);
        end
        check_val("busy", busy, q.size() != 0);
        pop = exp_rv && bus.res_ready;
        @(posedge clk);
        if (pop) void'(q.pop_front());
        if (found) begin
            idx     = sat_idx(acc_a[mdl_gnt]);
            e.id    = mdl_gnt;
            e.idx   = idx;
            e.avail = cyc + 2;
            q.push_back(e);
            ptr       = mdl_gnt;
            last_addr = idx;
        end
        armed = (rst_n == 1'b1);
        cyc++;
        #1;
    endtask

    function automatic bit any_valid();
        bit a;
        a = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) a |= v[i];
        return a;
    endfunction

    task automatic drain();
        int n;
        n = 0;
        bus.res_ready = 1'b1;
        drive_next('0, 0);
        while ((any_valid() || q.size() != 0) && n < 100) begin
            cycle();
            drive_next('0, 0);
            n++;
        end
        if (n >= 100) check_val("drain_timeout", q.size(), 0);
    endtask

    task automatic check_reset(input string p);
        check_val({p, "_lut_addr"}, lut_addr, 8'h80);
        check_val({p, "_res_valid"}, bus.res_valid, 0);
        check_val({p, "_res_data"}, bus.res_data, 0);
        check_val({p, "_res_id"}, bus.res_id, 0);
        check_val({p, "_busy"}, busy, 0);
        check_val({p, "_req_ready"}, bus.req_ready, 0);
    endtask

    function automatic int onehot_id(input logic [NUM_REQ-1:0] x);
        int r;
        r = -1;
        for (int i = 0; i < NUM_REQ; i++) if (x[i]) r = i;
        return r;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int prev, id, nx;
        int cnt [NUM_REQ];
        cyc = 0;
        for (int i = 0; i < 256; i++) lut_mem[i] = 16'($urandom);
        for (int i = 0; i < NUM_REQ; i++) begin
            v[i]     = 1'b0;
            acc_a[i] = '0;
        end
        bus.req_valid = '0;
        bus.req_acc   = '0;
        bus.res_ready = 1'b0;
        model_reset();

        // Reset values, with requests pending to show no grant leaks out
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < NUM_REQ; i++) v[i] = 1'b1;
        apply();
        #1;
        check_reset("rst");
        for (int i = 0; i < NUM_REQ; i++) v[i] = 1'b0;
        apply();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.res_ready = 1'b1;
        cycle();

        // Single request of +1.0 from requester 0
        v[0] = 1'b1;
        acc_a[0] = 24'h001000;
        apply();
        cycle();
        check_val("single_gnt", obs_xfer, 4'b0001);
        drive_next('0, 0);
        check_val("single_addr", lut_addr, 8'h90);
        cycle();
        check_val("single_res_valid", bus.res_valid, 1);
        check_val("single_res_data", bus.res_data, lut_mem[8'h90]);
        check_val("single_res_id", bus.res_id, 0);

        // Saturation and index corner cases
        for (int k = 0; k < 5; k++) begin
            v[0] = 1'b1;
            acc_a[0] = sat_acc[k];
            apply();
            cycle();
            check_val("sat_gnt", obs_xfer, 4'b0001);
            drive_next('0, 0);
            check_val("sat_addr", lut_addr, sat_exp[k]);
        end

        // All requesters held valid: one grant per cycle in rotating order
        drain();
        drive_next('1, 100);
        prev = -1;
        repeat (16) begin
            cycle();
            check_val("rr_one_per_cycle", $countones(obs_xfer), 1);
            id = onehot_id(obs_xfer);
            if (prev >= 0) check_val("rr_order", id, (prev + 1) % NUM_REQ);
            prev = id;
            drive_next('1, 100);
        end

        // Backpressure: credits exhaust after RES_DEPTH grants, then drain and resume
        drain();
        bus.res_ready = 1'b0;
        drive_next('1, 100);
        nx = 0;
        repeat (10) begin
            cycle();
            nx += $countones(obs_xfer);
            drive_next('1, 100);
        end
        check_val("bp_grants", nx, RES_DEPTH);
        check_val("bp_req_ready", bus.req_ready, 0);
        bus.res_ready = 1'b1;
        repeat (8) begin
            cycle();
            drive_next('1, 100);
        end

        // Requesters 1 and 3 only, pointer parked on 1
        drain();
        v[1] = 1'b1;
        acc_a[1] = rand_acc();
        apply();
        cycle();
        check_val("alt_pre_gnt", obs_xfer, 4'b0010);
        drive_next('0, 0);
        drive_next(4'b1010, 100);
        for (int i = 0; i < NUM_REQ; i++) cnt[i] = 0;
        for (int n = 0; n < 12; n++) begin
            cycle();
            if (n == 0) check_val("alt_first_gnt", obs_xfer, 4'b1000);
            for (int i = 0; i < NUM_REQ; i++) cnt[i] += int'(obs_xfer[i]);
            drive_next(4'b1010, 100);
        end
        check_val("alt_cnt0", cnt[0], 0);
        check_val("alt_cnt1", cnt[1], 6);
        check_val("alt_cnt2", cnt[2], 0);
        check_val("alt_cnt3", cnt[3], 6);

        // Random traffic with random backpressure
        drain();
        repeat (400) begin
            bus.res_ready = (int'($urandom_range(99)) < 70);
            cycle();
            drive_next(NUM_REQ'($urandom), 50);
        end

        // Asynchronous reset with reads in flight and results queued
        drain();
        bus.res_ready = 1'b0;
        drive_next('1, 100);
        repeat (3) begin
            cycle();
            drive_next('1, 100);
        end
        check_val("arst_pre_busy", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset("arst");
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.res_ready = 1'b1;
        cycle();
        drive_next('1, 100);
        cycle();
        check_val("arst_first_gnt", obs_xfer, 4'b0001);
        drive_next('1, 100);
        repeat (40) begin
            bus.res_ready = (int'($urandom_range(99)) < 60);
            cycle();
            drive_next(NUM_REQ'($urandom), 60);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
